// File: rtl/if_pkg.sv
// if_pkg -- shared definitions for the instruction-fetch stage.
//   if_state_e       : fetch FSM states (FETCH, HOLD, DRAIN)
//   NOP              : bubble word presented when no instruction is valid
//   PC_STEP_DEFAULT  : default sequential PC increment
//   pc_add()         : 32-bit modulo PC adder shared by the PC register
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // requesting imem at PC, waiting for ack
    HOLD  = 2'd1,  // word captured while downstream frozen; imem idle
    DRAIN = 2'd2   // branch arrived mid-request; wait out the stale ack
  } if_state_e;

  localparam logic [31:0] NOP             = 32'd0;
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

  // Plain 32-bit add; the carry out is dropped so the PC wraps modulo 2^32.
  function automatic logic [31:0] pc_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/if_stage_pc_register.sv
// pc_register -- program counter storage for the fetch stage.
//   clk, rst       : clock, synchronous active-high reset (loads RESET_PC)
//   load, load_addr: redirect; load has priority over inc
//   inc            : advance by PC_STEP
//   pc             : current PC (the address being fetched)
//   pc_seq         : pc + PC_STEP, wrapping modulo 2^32
module pc_register
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc,
  output logic [31:0] pc_seq
);

  logic [31:0] pc_q;

  assign pc     = pc_q;
  assign pc_seq = pc_add(pc_q, PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_addr;
    end else if (inc) begin
      pc_q <= pc_seq;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with hold buffer and branch drain.
//   Parameters : RESET_PC (PC after reset), PC_STEP (sequential increment)
//   clk, rst   : clock, synchronous active-high reset
//   freeze     : downstream IF/ID hold request
//   branch_taken, branch_addr : redirect from execute (beats freeze)
//   imem_req, imem_addr       : instruction-memory read request / address
//   imem_ack, imem_rdata      : read data valid / read data
//   PC          : PC of presented instruction plus PC_STEP
//   instruction : presented word, NOP when out_valid is low
//   out_valid   : instruction/PC usable this cycle
//   if_stall    : ~out_valid
//   state_dbg   : current FSM state, for observation only
//   Optional (macro IF_PERF_CNT_EN): fetch_count, stall_count, 32-bit
//   wrapping counters cleared by rst.
//
// Memory handshake: imem_req is the valid side, imem_ack the ready side.
// A transfer happens in any cycle where imem_req && imem_ack are both high;
// the ack may come in the same cycle as the request. While imem_req is high
// and no ack has arrived, imem_addr is held stable. imem_req drops only when
// the stage cannot accept a word (HOLD) or during reset; a request is never
// withdrawn mid-flight except by reset.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        out_valid,
  output logic        if_stall,
  output if_state_e   state_dbg
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] hold_buf_q;
  logic [31:0] target_q, target_d;
  logic        buf_we;
  logic        pc_load, pc_inc;
  logic [31:0] pc_load_addr;
  logic [31:0] pc_cur, pc_seq;

  pc_register #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc_cur),
    .pc_seq    (pc_seq)
  );

  assign imem_addr = pc_cur;
  assign PC        = pc_seq;
  assign if_stall  = ~out_valid;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      hold_buf_q <= NOP;
      target_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (buf_we) begin
        hold_buf_q <= imem_rdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    buf_we       = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load_addr = branch_addr;
    imem_req     = 1'b0;
    out_valid    = 1'b0;
    instruction  = NOP;

    // All outputs stay quiet in reset; pc_register resets itself.
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (branch_taken) begin
              // Returned word is on the wrong path: drop it.
              pc_load = 1'b1;
            end else begin
              out_valid   = 1'b1;
              instruction = imem_rdata;
              if (freeze) begin
                buf_we  = 1'b1;
                state_d = HOLD;
              end else begin
                pc_inc = 1'b1;
              end
            end
          end else if (branch_taken) begin
            // Cannot abandon the outstanding read; remember where to go.
            target_d = branch_addr;
            state_d  = DRAIN;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            pc_load = 1'b1;
            state_d = FETCH;
          end else begin
            out_valid   = 1'b1;
            instruction = hold_buf_q;
            if (!freeze) begin
              pc_inc  = 1'b1;
              state_d = FETCH;
            end
          end
        end

        DRAIN: begin
          imem_req = 1'b1;
          // A newer branch supersedes the remembered target, including in
          // the cycle the stale ack arrives.
          if (branch_taken) begin
            target_d = branch_addr;
          end
          if (imem_ack) begin
            pc_load      = 1'b1;
            pc_load_addr = branch_taken ? branch_addr : target_q;
            state_d      = FETCH;
          end
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // out_valid already excludes branch_taken; the explicit term keeps the
  // accepted-fetch condition readable on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (out_valid && !freeze && !branch_taken) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!out_valid) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- directed test of if_stage with hand-computed expectations.
// Memory is modelled by driving imem_ack / imem_rdata directly each cycle;
// data words are 32'hC000_0000 | address so the source is recognisable.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        out_valid;
  logic        if_stall;
  if_state_e   state_dbg;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int tests    = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .PC           (pc_out),
    .instruction  (instruction),
    .out_valid    (out_valid),
    .if_stall     (if_stall),
    .state_dbg    (state_dbg)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are checked 1 time
  // unit later, well away from the rising edge.
  task automatic set_in(input logic r, input logic fr, input logic br,
                        input logic [31:0] ba, input logic ak,
                        input logic [31:0] rd);
    rst          = r;
    freeze       = fr;
    branch_taken = br;
    branch_addr  = ba;
    imem_ack     = ak;
    imem_rdata   = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- checkers ----------------
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input if_state_e exp);
    tests++;
    assert (state_dbg === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, state_dbg, exp);
    end
  endtask

  // Checks the full presented-instruction picture in one call.
  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] pcv, input logic ov, input logic [31:0] ins);
    chk1 ({tag, ".req"},   imem_req,    req);
    chk32({tag, ".addr"},  imem_addr,   addr);
    chk32({tag, ".pc"},    pc_out,      pcv);
    chk1 ({tag, ".valid"}, out_valid,   ov);
    chk1 ({tag, ".stall"}, if_stall,    ~ov);
    chk32({tag, ".instr"}, instruction, ins);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset: nothing requested, PC reads RESET_PC+4, addr reads RESET_PC.
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1234_5678);
    chk_out("reset", 1'b0, 32'd0, 32'd4, 1'b0, 32'd0);
    chk_state("reset.state", FETCH);
`ifdef IF_PERF_CNT_EN
    chk32("reset.fetch_cnt", fetch_count, 32'd0);
    chk32("reset.stall_cnt", stall_count, 32'd0);
`endif
    tick();

    // Zero-wait memory streaming, one instruction per cycle.
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0000);
    chk_out("seq0", 1'b1, 32'd0, 32'd4, 1'b1, 32'hC000_0000);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0004);
    chk_out("seq4", 1'b1, 32'd4, 32'd8, 1'b1, 32'hC000_0004);
    tick();

    // Ack at 8 with freeze: word presented and captured, PC held.
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hC000_0008);
    chk_out("frz8", 1'b1, 32'd8, 32'd12, 1'b1, 32'hC000_0008);
    tick();
    // HOLD: memory idle, buffer presented even with garbage on rdata.
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);
    chk_state("hold1.state", HOLD);
    chk_out("hold1", 1'b0, 32'd8, 32'd12, 1'b1, 32'hC000_0008);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
    chk_out("hold2", 1'b0, 32'd8, 32'd12, 1'b1, 32'hC000_0008);
    tick();
    // Freeze released: still presenting the buffer, advance this edge.
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);
    chk_out("hold3", 1'b0, 32'd8, 32'd12, 1'b1, 32'hC000_0008);
    tick();

    // Fetch 12 waits; branch to 0x100 during the wait -> DRAIN.
    set_in(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
    chk_state("br12.state", FETCH);
    chk_out("br12", 1'b1, 32'd12, 32'd16, 1'b0, 32'd0);
    tick();
    // Stale ack for 12 arrives: request still at 12, data dropped.
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_000C);
    chk_state("drain.state", DRAIN);
    chk_out("drain", 1'b1, 32'd12, 32'd16, 1'b0, 32'd0);
    tick();

    // Two-cycle fetch at the branch target.
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_state("t100w.state", FETCH);
    chk_out("t100w", 1'b1, 32'h100, 32'h104, 1'b0, 32'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0100);
    chk_out("t100a", 1'b1, 32'h100, 32'h104, 1'b1, 32'hC000_0100);
    tick();

    // Branch to 0x200 in wait, then 0x300 in DRAIN overwrites it.
    set_in(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0);
    chk_out("br104", 1'b1, 32'h104, 32'h108, 1'b0, 32'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
    chk_state("drain2.state", DRAIN);
    chk_out("drain2", 1'b1, 32'h104, 32'h108, 1'b0, 32'd0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0104);
    chk_out("drain2ack", 1'b1, 32'h104, 32'h108, 1'b0, 32'd0);
    tick();

    // Ack at 0x300 with freeze -> HOLD; then branch+freeze drops buffer.
    set_in(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hC000_0300);
    chk_out("frz300", 1'b1, 32'h300, 32'h304, 1'b1, 32'hC000_0300);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'd0);
    chk_state("holdbr.state", HOLD);
    chk_out("holdbr", 1'b0, 32'h300, 32'h304, 1'b0, 32'd0);
    tick();

    // Branch with ack at 0x400 to the top of the address space.
    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hC000_0400);
    chk_state("br400.state", FETCH);
    chk_out("br400", 1'b1, 32'h400, 32'h404, 1'b0, 32'd0);
    tick();
    // Accept at 0xFFFFFFFC: PC output and next address wrap to 0.
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_FFFC);
    chk_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'hC000_FFFC);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0000);
    chk_out("wrap0", 1'b1, 32'd0, 32'd4, 1'b1, 32'hC000_0000);
    tick();

    // Request at 4 pending when reset arrives: abandoned.
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_out("pend4", 1'b1, 32'd4, 32'd8, 1'b0, 32'd0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0004);
    chk_out("midrst", 1'b0, 32'd4, 32'd8, 1'b0, 32'd0);
    tick();

    // After reset: three stall cycles at RESET_PC, then ten accepted fetches.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk32("stall.addr", imem_addr, 32'd0);
      chk1("stall.req", imem_req, 1'b1);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hC000_0000 | 32'(i * 4));
      chk32("run.addr", imem_addr, 32'(i * 4));
      chk32("run.instr", instruction, 32'hC000_0000 | 32'(i * 4));
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk32("run.end_addr", imem_addr, 32'd40);
`ifdef IF_PERF_CNT_EN
    chk32("perf.fetch_cnt", fetch_count, 32'd10);
    chk32("perf.stall_cnt", stall_count, 32'd3);
`endif

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
